// File: rtl/text_scroller_pkg.sv
// ============================================================================
// text_scroller_pkg : shared constants and state encoding for text_scroller
// Rev 1.0
// ============================================================================
`default_nettype none

package text_scroller_pkg;

    localparam logic [7:0] c_BLANK         = 8'h20;
    localparam int         c_DEPTH_DEFAULT = 16;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/text_scroller_scroll_window.sv
// ============================================================================
// scroll_window : maps buffer/len/pos to the 4-character display window,
//                 treating the message as followed by four blanks (period len+4)
// Rev 1.0
// ============================================================================
`default_nettype none

module scroll_window
    import text_scroller_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic [DEPTH-1:0][7:0] i_buf,
    input  logic [4:0]            i_len,
    input  logic [5:0]            i_pos,
    output logic [31:0]           o_window
);

    logic [5:0] w_len6;
    logic [5:0] w_period;

    assign w_len6   = {1'b0, i_len};
    assign w_period = w_len6 + 6'd4;

    for (genvar k = 0; k < 4; k++) begin : g_digit
        logic [5:0] w_raw;
        logic [5:0] w_idx;
        logic [7:0] w_char;

        // pos < period and k <= 3 < period, so a single subtraction wraps
        assign w_raw = i_pos + 6'(k);
        assign w_idx = (w_raw >= w_period) ? (w_raw - w_period) : w_raw;

        always_comb begin
            w_char = c_BLANK;
            for (int j = 0; j < DEPTH; j++) begin
                if ((w_idx == 6'(j)) && (w_idx < w_len6)) begin
                    w_char = i_buf[j];
                end
            end
        end

        assign o_window[31-8*k -: 8] = w_char;
    end

endmodule

`default_nettype wire

// File: rtl/text_scroller.sv
// ============================================================================
// text_scroller : character buffer with a stepped 4-digit scrolling window
// Rev 1.0
// ============================================================================
`default_nettype none

module text_scroller
    import text_scroller_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [7:0]  wr_char,
    output logic        wr_ready,
    input  logic        clear,
    input  logic        step,
    input  logic        pause,
    output logic [31:0] word,
    output logic [4:0]  len
);

    localparam logic [5:0] c_DEPTH = 6'(DEPTH);

    state_t                r_state;
    state_t                w_state_next;
    logic [4:0]            r_len;
    logic [4:0]            w_len_next;
    // Six bits so pos can reach DEPTH+3 when DEPTH is at its upper limit
    logic [5:0]            r_pos;
    logic [5:0]            w_pos_next;
    logic [DEPTH-1:0][7:0] r_buf;
    logic [31:0]           r_word;
    logic [31:0]           w_window;
    logic [5:0]            w_period_old;
    logic                  w_write;
    logic                  w_step;

    assign wr_ready     = ({1'b0, r_len} < c_DEPTH) && !clear && !reset;
    assign w_write      = wr_valid && wr_ready;
    assign w_step       = step && !pause && (r_state == ST_SHOW);
    assign w_period_old = {1'b0, r_len} + 6'd4;

    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_pos_next   = r_pos;
        if (clear) begin
            w_state_next = ST_EMPTY;
            w_len_next   = 5'd0;
            w_pos_next   = 6'd0;
        end else begin
            if (w_write) begin
                w_len_next   = r_len + 5'd1;
                w_state_next = ST_SHOW;
            end
            if (w_step) begin
                w_pos_next = (r_pos == w_period_old - 6'd1) ? 6'd0 : r_pos + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_len   <= 5'd0;
            r_pos   <= 6'd0;
        end else begin
            r_state <= w_state_next;
            r_len   <= w_len_next;
            r_pos   <= w_pos_next;
        end
    end

    // Contents survive reset; they are hidden while len is zero
    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            if (w_write && (r_len == 5'(j))) begin
                r_buf[j] <= wr_char;
            end
        end
    end

    scroll_window #(
        .DEPTH (DEPTH)
    ) u_scroll_window (
        .i_buf    (r_buf),
        .i_len    (r_len),
        .i_pos    (r_pos),
        .o_window (w_window)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word <= {4{c_BLANK}};
        end else begin
            r_word <= w_window;
        end
    end

    assign word = r_word;
    assign len  = r_len;

endmodule

`default_nettype wire

// File: tb/tb_text_scroller.sv
// ============================================================================
// tb_text_scroller : directed stimulus with a cycle-tagged expectation queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_text_scroller;

    localparam int DEPTH  = 8;
    localparam int K_WORD = 0;
    localparam int K_LEN  = 1;
    localparam int K_RDY  = 2;
    localparam logic [31:0] SPACES = 32'h20202020;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [7:0]  wr_char;
    logic        wr_ready;
    logic        clear;
    logic        step;
    logic        pause;
    logic [31:0] word;
    logic [4:0]  len;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mon_act;
    logic        drain_req  = 1'b0;
    logic        drain_done = 1'b0;

    text_scroller #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_char  (wr_char),
        .wr_ready (wr_ready),
        .clear    (clear),
        .step     (step),
        .pause    (pause),
        .word     (word),
        .len      (len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectation is checked on the falling edge n rising edges from now
    function automatic void exp_push(int n, int kind, logic [31:0] v, string nm);
        q.push_back('{cyc + n, kind, v, nm});
    endfunction

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                case (q[i].kind)
                    K_WORD:  mon_act = word;
                    K_LEN:   mon_act = {27'd0, len};
                    default: mon_act = {31'd0, wr_ready};
                endcase
                checks++;
                if (mon_act !== q[i].val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", q[i].name, mon_act, q[i].val, cyc);
                end
                q.delete(i);
            end
        end
        if (drain_req && !drain_done) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d unchecked entries expected 0", q.size());
            end
            drain_done = 1'b1;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(logic [7:0] c);
        wr_valid = 1'b1;
        wr_char  = c;
        tick();
        wr_valid = 1'b0;
    endtask

    logic [31:0] seq [9];

    initial begin
        seq = '{"ello", "llo ", "lo  ", "o   ", "    ", "   h", "  he", " hel", "hell"};
        reset = 1'b1; wr_valid = 1'b0; wr_char = 8'h00;
        clear = 1'b0; step = 1'b0; pause = 1'b0;

        // Reset state
        tick(2);
        exp_push(0, K_RDY, 32'd0, "ready_in_reset");
        tick();
        reset = 1'b0;
        exp_push(0, K_WORD, SPACES, "reset_word");
        exp_push(0, K_LEN,  32'd0,  "reset_len");
        exp_push(0, K_RDY,  32'd1,  "reset_ready");
        tick();

        // "hello" and a full scroll period with wrap
        wr("h"); wr("e"); wr("l"); wr("l"); wr("o");
        exp_push(0, K_LEN,  32'd5, "hello_len");
        exp_push(1, K_WORD, "hell", "hello_word0");
        for (int i = 0; i < 9; i++) begin
            step = 1'b1;
            exp_push(2, K_WORD, seq[i], "scroll");
            tick();
        end
        step = 1'b0;
        tick();

        // Pause holds the window
        pause = 1'b1;
        step  = 1'b1;
        tick(3);
        step = 1'b0;
        exp_push(1, K_WORD, "hell", "pause_hold");
        tick();
        pause = 1'b0;
        step  = 1'b1;
        exp_push(2, K_WORD, "ello", "pause_release");
        tick();
        step = 1'b0;
        tick(2);

        // Clear beats a simultaneous write and step
        clear = 1'b1; tick(); clear = 1'b0;
        wr("x"); wr("y"); wr("z");
        step = 1'b1; tick(2); step = 1'b0;
        clear = 1'b1; wr_valid = 1'b1; wr_char = "q"; step = 1'b1;
        exp_push(0, K_RDY,  32'd0,  "clear_ready");
        exp_push(1, K_LEN,  32'd0,  "clear_len");
        exp_push(1, K_WORD, "z   ", "clear_old_word");
        exp_push(2, K_WORD, SPACES, "clear_word");
        tick();
        clear = 1'b0; wr_valid = 1'b0; step = 1'b0;
        exp_push(0, K_RDY, 32'd1, "clear_ready_after");
        tick(2);

        // Step in EMPTY ignored; wrap on pre-write period
        step = 1'b1; tick(2); step = 1'b0;
        wr("a"); wr("b");
        exp_push(1, K_WORD, "ab  ", "empty_step_ignored");
        step = 1'b1; tick(5); step = 1'b0;
        exp_push(1, K_WORD, " ab ", "pos5_word");
        tick();
        wr_valid = 1'b1; wr_char = "c"; step = 1'b1;
        exp_push(1, K_LEN,  32'd3,  "wrap_len");
        exp_push(2, K_WORD, "abc ", "wrap_p_old");
        tick();
        wr_valid = 1'b0; step = 1'b0;
        tick(2);

        // Fill to capacity with extra writes dropped
        clear = 1'b1; tick(); clear = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            wr_char = 8'h41 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        exp_push(0, K_LEN,  32'(DEPTH), "full_len");
        exp_push(0, K_RDY,  32'd0,      "full_ready");
        exp_push(1, K_WORD, "ABCD",     "full_word");
        step = 1'b1; tick(DEPTH - 1); step = 1'b0;
        exp_push(1, K_WORD, {8'h41 + 8'(DEPTH - 1), 24'h202020}, "full_last_char");
        exp_push(1, K_LEN,  32'(DEPTH), "full_len_hold");
        tick(2);

        // Reset mid-operation discards write and step
        reset = 1'b1; wr_valid = 1'b1; wr_char = "Z"; step = 1'b1;
        exp_push(0, K_RDY,  32'd0,  "rst_ready");
        exp_push(1, K_LEN,  32'd0,  "rst_len");
        exp_push(1, K_WORD, SPACES, "rst_word");
        tick();
        reset = 1'b0; wr_valid = 1'b0; step = 1'b0;
        exp_push(0, K_RDY,  32'd1,  "rst_ready_after");
        exp_push(2, K_WORD, SPACES, "rst_word_after");
        tick(3);

        drain_req = 1'b1;
        for (int i = 0; i < 10 && !drain_done; i++) tick();
        if (!drain_done) begin
            errors++;
            $display("FAIL drain_timeout: got no drain expected drain");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
